// File: rtl/param_stream_mux_pkg.sv
// Shared constants and helpers for the parameterised stream multiplexer.
// No logic of its own; used at elaboration time only.
// Not applicable: holds no datapath and applies no flow control.
package stream_mux_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    // Ceiling log2, never below 1 so that a 2-way mux still gets a 1-bit index.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/param_stream_mux_rr_arbiter.sv
// Rotate-priority encoder: first asserted request at or above ptr, wrapping modulo N_IN.
// Latency: purely combinational.
// Backpressure: none; the grant is simply qualified by the caller's load condition.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int  N_IN  = 2,
    localparam int SEL_W = clog2(N_IN)
) (
    input  logic [N_IN-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic             gnt_vld,
    output logic [SEL_W-1:0] gnt_idx
);

    // Walk the offsets from farthest to nearest so the nearest requester is written last and wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = N_IN - 1; k >= 0; k--) begin
            int c;
            c = int'(ptr) + k;
            if (c >= N_IN) begin
                c = c - N_IN;
            end
            if (req[c]) begin
                gnt_vld = 1'b1;
                gnt_idx = SEL_W'(c);
            end
        end
    end

endmodule

// File: rtl/param_stream_mux.sv
// N_IN-way valid/ready stream mux, fixed-select or round-robin, with optional packet lock (PARAM_STREAM_MUX_PKT_LOCK_EN).
// Latency: 1 cycle from input handshake to out_valid; full 1 beat/cycle throughput.
// Backpressure: out_valid && !out_ready holds the output register and drops every in_ready.
module param_stream_mux
    import stream_mux_pkg::*;
#(
    parameter int  WIDTH = 8,
    parameter int  N_IN  = 2,
    localparam int SEL_W = clog2(N_IN)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [N_IN-1:0]       in_valid,
    output logic [N_IN-1:0]       in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
`ifdef PARAM_STREAM_MUX_PKT_LOCK_EN
    input  logic [N_IN-1:0]       in_last,
    output logic                  out_last,
`endif
    output logic [SEL_W-1:0]      out_src
);

    logic             load;
    logic             rr_vld;
    logic [SEL_W-1:0] rr_idx;
    logic [SEL_W-1:0] rr_ptr;
    logic             gnt_vld;
    logic [SEL_W-1:0] gnt_idx;
    logic [WIDTH-1:0] gnt_dat;
    logic             gnt_in_vld;
    logic             gnt_last;
    logic             xfer;
`ifdef PARAM_STREAM_MUX_PKT_LOCK_EN
    logic             lock;
    logic [SEL_W-1:0] lock_idx;
`endif

    assign load = !out_valid || out_ready;
    assign xfer = gnt_vld && gnt_in_vld && load;

    rr_arbiter #(.N_IN(N_IN)) u_arb (
        .req     (in_valid),
        .ptr     (rr_ptr),
        .gnt_vld (rr_vld),
        .gnt_idx (rr_idx)
    );

    // Pick the single granted channel; fixed mode grants sel whether or not it is valid, so ready never waits on valid.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        if (mode == MODE_RR) begin
            gnt_vld = rr_vld;
            gnt_idx = rr_idx;
        end else if (int'(sel) < N_IN) begin
            gnt_vld = 1'b1;
            gnt_idx = sel;
        end
`ifdef PARAM_STREAM_MUX_PKT_LOCK_EN
        if (lock) begin
            gnt_vld = 1'b1;
            gnt_idx = lock_idx;
        end
`endif
    end

    // Steer the granted channel's data, valid and last, and raise ready on that channel only.
    always_comb begin
        gnt_dat    = '0;
        gnt_in_vld = 1'b0;
        gnt_last   = 1'b1;
        in_ready   = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (gnt_idx == SEL_W'(i)) begin
                gnt_dat    = in_data[i*WIDTH +: WIDTH];
                gnt_in_vld = in_valid[i];
`ifdef PARAM_STREAM_MUX_PKT_LOCK_EN
                gnt_last   = in_last[i];
`endif
                in_ready[i] = reset_n && gnt_vld && load;
            end
        end
    end

    // Output register: take a new beat on transfer, otherwise drain when downstream accepts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
`ifdef PARAM_STREAM_MUX_PKT_LOCK_EN
            out_last  <= 1'b0;
`endif
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= gnt_dat;
            out_src   <= gnt_idx;
`ifdef PARAM_STREAM_MUX_PKT_LOCK_EN
            out_last  <= gnt_last;
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Round-robin pointer moves past the winner, but only once its packet (or single beat) is complete.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= '0;
        end else if (xfer && (mode == MODE_RR) && gnt_last) begin
            rr_ptr <= (gnt_idx == SEL_W'(N_IN - 1)) ? '0 : gnt_idx + SEL_W'(1);
        end
    end

`ifdef PARAM_STREAM_MUX_PKT_LOCK_EN
    // Hold the grant on a channel from its first non-last beat until its last beat transfers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock     <= 1'b0;
            lock_idx <= '0;
        end else if (xfer) begin
            lock     <= !gnt_last;
            lock_idx <= gnt_idx;
        end
    end
`endif

endmodule

// File: tb/tb_param_stream_mux.sv
// Bench for param_stream_mux: directed steps plus randomized traffic against a transaction-level model.
// Two instances: a 4-way mux (main checks) and a 3-way mux (out-of-range select).
// Build with PARAM_STREAM_MUX_PKT_LOCK_EN to also exercise packet lock.
module tb_param_stream_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    logic        mode4, oready4, ovalid4;
    logic [1:0]  sel4, osrc4;
    logic [31:0] data4;
    logic [3:0]  valid4, ready4;
    logic [7:0]  odata4;

    logic        mode3, oready3, ovalid3;
    logic [1:0]  sel3, osrc3;
    logic [23:0] data3;
    logic [2:0]  valid3, ready3;
    logic [7:0]  odata3;

`ifdef PARAM_STREAM_MUX_PKT_LOCK_EN
    logic [3:0] last4;
    logic       olast4;
    logic [2:0] last3;
    logic       olast3;
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    param_stream_mux #(.WIDTH(8), .N_IN(4)) u4 (
        .clk       (clk),
        .reset_n   (reset_n),
        .mode      (mode4),
        .sel       (sel4),
        .in_data   (data4),
        .in_valid  (valid4),
        .in_ready  (ready4),
        .out_data  (odata4),
        .out_valid (ovalid4),
        .out_ready (oready4),
`ifdef PARAM_STREAM_MUX_PKT_LOCK_EN
        .in_last   (last4),
        .out_last  (olast4),
`endif
        .out_src   (osrc4)
    );

    param_stream_mux #(.WIDTH(8), .N_IN(3)) u3 (
        .clk       (clk),
        .reset_n   (reset_n),
        .mode      (mode3),
        .sel       (sel3),
        .in_data   (data3),
        .in_valid  (valid3),
        .in_ready  (ready3),
        .out_data  (odata3),
        .out_valid (ovalid3),
        .out_ready (oready3),
`ifdef PARAM_STREAM_MUX_PKT_LOCK_EN
        .in_last   (last3),
        .out_last  (olast3),
`endif
        .out_src   (osrc3)
    );

    int total = 0;
    int bad   = 0;

    // Reference state for the 4-way instance: what sits in the output register and who is next in line.
    int m_vld = 0, m_dat = 0, m_src = 0, m_last = 0;
    int m_ptr = 0, m_lock = 0, m_lidx = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Which channel the rules say should be granted right now.
    task automatic grant4(output int has, output int g);
        has = 0;
        g   = 0;
        if (m_lock != 0) begin
            has = 1;
            g   = m_lidx;
        end else if (mode4 == 1'b0) begin
            if (int'(sel4) < 4) begin
                has = 1;
                g   = int'(sel4);
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                int c;
                c = (m_ptr + k) % 4;
                if (has == 0 && valid4[c]) begin
                    has = 1;
                    g   = c;
                end
            end
        end
    endtask

    // One clock of the 4-way instance: check ready before the edge, advance the model, check outputs after.
    task automatic cyc4(input string tag);
        int has, g, expr, lst;
        bit load, xfer;
        #1;
        grant4(has, g);
        load = (m_vld == 0) || oready4;
        expr = (has != 0 && load) ? (1 << g) : 0;
        chk({tag, " in_ready"}, 32'(ready4), 32'(expr));
        xfer = (has != 0) && load && valid4[g];
        lst  = 1;
`ifdef PARAM_STREAM_MUX_PKT_LOCK_EN
        lst  = int'(last4[g]);
`endif
        @(posedge clk);
        if (xfer) begin
            m_vld  = 1;
            m_dat  = int'(data4[g*8 +: 8]);
            m_src  = g;
            m_last = lst;
            if (mode4 == 1'b1 && lst != 0) m_ptr = (g + 1) % 4;
            if (LOCK_EN) begin
                m_lock = (lst == 0) ? 1 : 0;
                m_lidx = g;
            end
        end else if (oready4) begin
            m_vld = 0;
        end
        #1;
        chk({tag, " out_valid"}, 32'(ovalid4), 32'(m_vld));
        chk({tag, " out_data"},  32'(odata4),  32'(m_dat));
        chk({tag, " out_src"},   32'(osrc4),   32'(m_src));
`ifdef PARAM_STREAM_MUX_PKT_LOCK_EN
        chk({tag, " out_last"},  32'(olast4),  32'(m_last));
`endif
    endtask

    int exp_rr[5]  = '{0, 1, 2, 3, 0};
    int exp_sp[3]  = '{3, 0, 3};

    initial begin
        reset_n = 1'b0;
        mode4 = 1'b0; sel4 = 2'd1; valid4 = 4'hF; oready4 = 1'b1;
        data4 = {8'h00, 8'h00, 8'hB2, 8'hA1};
        mode3 = 1'b0; sel3 = 2'd0; valid3 = 3'b000; oready3 = 1'b1;
        data3 = {8'hCC, 8'hBB, 8'h55};
`ifdef PARAM_STREAM_MUX_PKT_LOCK_EN
        last4 = 4'hF;
        last3 = 3'h7;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready",  32'(ready4),  32'h0);
        chk("reset out_valid", 32'(ovalid4), 32'h0);
        chk("reset out_data",  32'(odata4),  32'h0);
        chk("reset out_src",   32'(osrc4),   32'h0);

        @(negedge clk);
        reset_n = 1'b1;
        cyc4("first");
        chk("first data", 32'(odata4), 32'hB2);
        chk("first src",  32'(osrc4),  32'h1);

        // Fixed select with a stalled consumer.
        sel4 = 2'd2; valid4 = 4'b0100; data4 = {8'h00, 8'h10, 8'h00, 8'h00};
        cyc4("bp beat0");
        chk("bp beat0 data", 32'(odata4), 32'h10);
        oready4 = 1'b0;
        data4 = {8'h00, 8'h11, 8'h00, 8'h00};
        for (int i = 0; i < 3; i++) begin
            cyc4("bp stall");
            chk("bp stall data",  32'(odata4), 32'h10);
            chk("bp stall ready", 32'(ready4), 32'h0);
        end
        oready4 = 1'b1;
        cyc4("bp beat1");
        chk("bp beat1 data", 32'(odata4), 32'h11);
        data4 = {8'h00, 8'h12, 8'h00, 8'h00};
        cyc4("bp beat2");
        chk("bp beat2 data",  32'(odata4),  32'h12);
        chk("bp beat2 valid", 32'(ovalid4), 32'h1);
        valid4 = 4'b0000;
        cyc4("bp drain");
        chk("bp drain valid", 32'(ovalid4), 32'h0);

        // Round-robin with every channel requesting.
        mode4 = 1'b1; valid4 = 4'hF; data4 = {8'h33, 8'h22, 8'h11, 8'h00};
        for (int i = 0; i < 5; i++) begin
            cyc4("rr full");
            chk("rr full src", 32'(osrc4), 32'(exp_rr[i]));
        end

        // Sparse round-robin starting from pointer 1.
        valid4 = 4'b1001;
        for (int i = 0; i < 3; i++) begin
            cyc4("rr sparse");
            chk("rr sparse src", 32'(osrc4), 32'(exp_sp[i]));
        end

`ifdef PARAM_STREAM_MUX_PKT_LOCK_EN
        // Channel 0 sends a 3-beat packet while channel 1 waits.
        valid4 = 4'b0011; last4 = 4'b0010;
        for (int i = 0; i < 2; i++) begin
            cyc4("lock body");
            chk("lock body src",  32'(osrc4),  32'h0);
            chk("lock body last", 32'(olast4), 32'h0);
        end
        last4 = 4'b0011;
        cyc4("lock tail");
        chk("lock tail src",  32'(osrc4),  32'h0);
        chk("lock tail last", 32'(olast4), 32'h1);
        cyc4("lock next");
        chk("lock next src", 32'(osrc4), 32'h1);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            mode4   = 1'($urandom);
            sel4    = 2'($urandom);
            valid4  = 4'($urandom);
            data4   = $urandom;
            oready4 = ($urandom_range(0, 3) != 0);
`ifdef PARAM_STREAM_MUX_PKT_LOCK_EN
            last4   = 4'($urandom);
`endif
            cyc4("random");
        end
        valid4 = 4'b0000;

        // 3-way instance: an index past the last channel grants nothing.
        valid3 = 3'b001; oready3 = 1'b0;
        @(posedge clk); #1;
        chk("oor load valid", 32'(ovalid3), 32'h1);
        chk("oor load data",  32'(odata3),  32'h55);
        chk("oor load src",   32'(osrc3),   32'h0);
        sel3 = 2'd3; valid3 = 3'b111;
        #1;
        chk("oor stall ready", 32'(ready3), 32'h0);
        @(posedge clk); #1;
        chk("oor stall valid", 32'(ovalid3), 32'h1);
        chk("oor stall data",  32'(odata3),  32'h55);
        oready3 = 1'b1;
        #1;
        chk("oor ready", 32'(ready3), 32'h0);
        @(posedge clk); #1;
        chk("oor drain valid", 32'(ovalid3), 32'h0);
        @(posedge clk); #1;
        chk("oor idle valid", 32'(ovalid3), 32'h0);
        chk("oor idle ready", 32'(ready3),  32'h0);
        sel3 = 2'd2;
        #1;
        chk("oor back ready", 32'(ready3), 32'h4);
        @(posedge clk); #1;
        chk("oor back data", 32'(odata3), 32'hCC);
        chk("oor back src",  32'(osrc3),  32'h2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/param_stream_mux.md
Name: param_stream_mux

Overview:
- N_IN-way, WIDTH-bit multiplexer with valid/ready handshaking on every input and on the output.
- Selection is either fixed by an external select or by a round-robin arbiter, chosen at runtime.
- The output is a single registered stage.
- Replaces ad-hoc chains of fixed 8-bit 2:1 muxes wherever datapath sources are shared between producers that stall.

Parameters:
- WIDTH, 8: data width per channel, >= 1.
- N_IN, 2: number of input channels, >= 2.
- SEL_W, $clog2(N_IN): select/index width, derived; not overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SEL_W  channel index used when mode=0.
- in_data  input  N_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N_IN  per-channel valid.
- in_ready  output  N_IN  per-channel ready; combinational.
- out_data  output  WIDTH  registered data.
- out_valid  output  1  registered valid.
- out_ready  input  1  downstream ready.
- out_src  output  SEL_W  index of the channel that produced the current out_data.

Behaviour:
- Reset (async assert, sync-safe deassert by system):
  - out_valid=0, out_data=0, out_src=0.
  - Round-robin pointer rr_ptr=0.
  - in_ready is 0 while reset_n=0.
- load = !out_valid || out_ready (combinational). The output register accepts a new beat only when load=1.
- Grant (combinational, at most one channel):
  - mode=0: candidate = sel.
    - If sel >= N_IN: no grant, all in_ready=0, out_valid drains normally.
  - mode=1: first channel with in_valid=1, searching from rr_ptr upward, modulo N_IN.
- in_ready[g] = load for the granted channel g. All other in_ready bits are 0.
  - In mode=0, in_ready[sel]=load even if in_valid[sel]=0, so ready does not depend on valid.
- Transfer on channel g when in_valid[g] && in_ready[g]. At that clock edge:
  - out_data <= in_data[g] slice.
  - out_src <= g.
  - out_valid <= 1.
- No transfer and out_ready=1 with out_valid=1: out_valid <= 0. out_data and out_src hold their values.
- Latency is 1 cycle from input handshake to out_valid.
- Full throughput of 1 beat/cycle is sustained while out_ready=1.
- Backpressure: if out_valid=1 and out_ready=0, out_data, out_src and out_valid are held stable and all in_ready=0.
- rr_ptr:
  - Updates only on a transfer while mode=1, to (g+1) mod N_IN. Wrap: g=N_IN-1 gives rr_ptr 0.
  - Unchanged in mode=0.
- mode or sel changes while out_valid=1: the registered beat is unaffected; the new selection applies from the next load cycle.
- Simultaneous transfer-in and transfer-out in the same cycle: the new beat replaces the old one with no bubble.

Optional Feature:
- Macro: PARAM_STREAM_MUX_PKT_LOCK_EN.
- When defined, the following are added:
  - in_last input, N_IN bits.
  - out_last output, 1 bit, registered alongside out_data, reset 0.
  - A lock register, reset 0.
- Lock behaviour:
  - A transfer with in_last[g]=0 sets lock and records lock_idx=g.
  - While lock=1, the grant is forced to lock_idx regardless of mode, sel or rr_ptr.
  - A transfer with in_last[lock_idx]=1 clears lock.
  - rr_ptr advances only on a transfer with last=1.
- When undefined:
  - No in_last/out_last ports.
  - Every beat is independently arbitrated, as described above.

Decomposition:
- Package stream_mux_pkg contains:
  - MODE_SEL=1'b0 and MODE_RR=1'b1 constants.
  - clog2 helper function.
- Sub-module rr_arbiter is natural. Interface:
  - Inputs: req[N_IN], ptr[SEL_W].
  - Outputs: gnt_vld, gnt_idx[SEL_W].
  - Purely combinational rotate-priority encoder.
- param_stream_mux owns rr_ptr, the lock, and the output register.

Test Plan:
- Reset: hold reset_n=0 with in_valid=2'b11 -> out_valid=0, out_data=0, in_ready=0. Release; first edge with mode=0, sel=1, in_data={8'hB2,8'hA1} -> next cycle out_data=8'hB2, out_src=1.
- Fixed select and backpressure, WIDTH=8, N_IN=4, mode=0, sel=2, ch2 streaming 8'h10,8'h11,8'h12:
  - With out_ready=0 for 3 cycles after the first beat -> out_data stays 8'h10 and in_ready=4'b0000.
  - Release -> 8'h11 and 8'h12 follow back-to-back.
- Round-robin fairness, N_IN=4, mode=1, all in_valid=1, out_ready=1 -> out_src sequence 0,1,2,3,0; rr_ptr wraps from 3 to 0.
- Sparse round-robin, N_IN=4, mode=1, in_valid=4'b1001, rr_ptr=1 -> grants 3 then 0 then 3.
- Out-of-range select, N_IN=3, mode=0, sel=3 -> in_ready=0 for all channels; a pending out_valid drains after out_ready=1 and no new beat appears.
- PARAM_STREAM_MUX_PKT_LOCK_EN, mode=1, ch0 sends 3 beats with last on beat 3 while ch1 is valid throughout -> out_src=0,0,0 then 1, out_last=1 only on the third beat.
